// File: rtl/stump_mem_responder_if.sv
// Stump core <-> memory bus: request strobes, address/data, and the
// responder's completion/error pulses.
interface stump_mem_responder_if;
    logic        mem_ren;
    logic        mem_wen;
    logic [15:0] address;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        mem_ready;
    logic        err;

    // Strobes are level requests sampled only while the responder is idle;
    // mem_ready marks the single RESP cycle, err pulses for illegal requests.
    modport master (
        output mem_ren, mem_wen, address, data_in,
        input  data_out, mem_ready, err
    );

    modport slave (
        input  mem_ren, mem_wen, address, data_in,
        output data_out, mem_ready, err
    );
endinterface

// File: rtl/stump_mem_responder.sv
// Word-addressed RAM responder for the Stump core with programmable wait
// states, one-cycle ready/error pulses and completed-access counters.
module stump_mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    stump_mem_responder_if.slave  bus,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count,
    output logic [1:0]            state_dbg
);

    localparam int         DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WS_M1 = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [3:0]              r_wcnt;
    logic [15:0]             r_addr;
    logic [15:0]             r_data;
    logic                    r_is_write;
    logic [15:0]             r_data_out;
    logic                    r_err_both;
    logic [15:0]             r_rd_count;
    logic [15:0]             r_wr_count;
    logic [15:0]             r_mem [0:DEPTH-1];

    logic                    w_accept;
    logic                    w_both;
    logic [15:0]             w_rd_addr;
    logic                    w_rd_in_range;
    logic                    w_is_read;
    logic                    w_addr_ok;

    assign w_accept = (r_state == S_IDLE) && (bus.mem_ren ^ bus.mem_wen);
    assign w_both   = (r_state == S_IDLE) && bus.mem_ren && bus.mem_wen;

    // With zero wait states the RAM is read straight off the bus in the accept cycle.
    assign w_rd_addr     = (r_state == S_IDLE) ? bus.address : r_addr;
    assign w_rd_in_range = (w_rd_addr[15:DEPTH_LOG2] == '0);
    assign w_is_read     = (r_state == S_IDLE) ? bus.mem_ren : !r_is_write;
    assign w_addr_ok     = (r_addr[15:DEPTH_LOG2] == '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_wcnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wcnt     <= 4'd0;
            r_addr     <= 16'h0000;
            r_data     <= 16'h0000;
            r_is_write <= 1'b0;
            r_data_out <= 16'h0000;
            r_err_both <= 1'b0;
            r_rd_count <= 16'h0000;
            r_wr_count <= 16'h0000;
        end else begin
            r_state    <= w_next;
            r_err_both <= w_both;
            if (w_accept) begin
                r_addr     <= bus.address;
                r_data     <= bus.data_in;
                r_is_write <= bus.mem_wen;
                r_wcnt     <= WS_M1;
            end else if (r_state == S_WAIT && r_wcnt != 4'd0) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
            if (w_next == S_RESP && r_state != S_RESP && w_is_read) begin
                r_data_out <= w_rd_in_range ? r_mem[w_rd_addr[DEPTH_LOG2-1:0]] : 16'h0000;
            end
            if (r_state == S_RESP && w_addr_ok) begin
                if (r_is_write) begin
                    r_wr_count <= r_wr_count + 16'd1;
                end else begin
                    r_rd_count <= r_rd_count + 16'd1;
                end
            end
        end
    end

    // RAM has no reset; a write lands only if reset is low at the edge leaving RESP.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_RESP && r_is_write && w_addr_ok) begin
            r_mem[r_addr[DEPTH_LOG2-1:0]] <= r_data;
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.mem_ready = (r_state == S_RESP);
    assign bus.err       = r_err_both || ((r_state == S_RESP) && !w_addr_ok);
    assign rd_count      = r_rd_count;
    assign wr_count      = r_wr_count;
    assign state_dbg     = r_state;

endmodule

// File: tb/tb_stump_mem_responder.sv
// Bench for stump_mem_responder: a zero-wait and a one-wait instance share
// stimulus and are checked against a transaction-level memory model.
module tb_stump_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stump_mem_responder_if if0 ();
    stump_mem_responder_if if1 ();

    logic [15:0] rd0, wr0, rd1, wr1;
    logic [1:0]  st0, st1;

    stump_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave),
        .rd_count(rd0), .wr_count(wr0), .state_dbg(st0)
    );

    stump_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave),
        .rd_count(rd1), .wr_count(wr1), .state_dbg(st1)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: word memory plus expected visible registers.
    logic [15:0] mem_m [0:255];
    logic [15:0] exp_dout;
    logic [15:0] exp_rd;
    logic [15:0] exp_wr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ren, input logic wen, input logic [15:0] addr, input logic [15:0] din);
        if0.mem_ren = ren; if0.mem_wen = wen; if0.address = addr; if0.data_in = din;
        if1.mem_ren = ren; if1.mem_wen = wen; if1.address = addr; if1.data_in = din;
    endtask

    task automatic check_regs(input string tag);
        check_eq({tag, "/dout0"}, if0.data_out, exp_dout);
        check_eq({tag, "/dout1"}, if1.data_out, exp_dout);
        check_eq({tag, "/rd0"}, rd0, exp_rd);
        check_eq({tag, "/rd1"}, rd1, exp_rd);
        check_eq({tag, "/wr0"}, wr0, exp_wr);
        check_eq({tag, "/wr1"}, wr1, exp_wr);
    endtask

    // kind: 0 read, 1 write, 2 both strobes. Strobes held one cycle (cycle 0),
    // outputs observed over cycles 1..4 for both instances.
    task automatic run_txn(input int kind, input logic [15:0] addr, input logic [15:0] din, input string tag);
        int rn[2], rc[2], en[2], ec[2];
        logic ear[2];
        logic [15:0] dr[2];
        logic in_range;
        for (int d = 0; d < 2; d++) begin
            rn[d] = 0; rc[d] = -1; en[d] = 0; ec[d] = -1; ear[d] = 1'b0; dr[d] = 16'h0;
        end
        @(negedge clk);
        drive(kind != 1, kind != 0, addr, din);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) drive(1'b0, 1'b0, 16'h0, 16'h0);
            if (if0.mem_ready) begin rn[0]++; rc[0] = c; dr[0] = if0.data_out; ear[0] = if0.err; end
            if (if0.err)       begin en[0]++; ec[0] = c; end
            if (if1.mem_ready) begin rn[1]++; rc[1] = c; dr[1] = if1.data_out; ear[1] = if1.err; end
            if (if1.err)       begin en[1]++; ec[1] = c; end
        end
        in_range = (addr[15:8] == 8'h00);
        if (kind == 0) exp_dout = in_range ? mem_m[addr[7:0]] : 16'h0000;
        for (int d = 0; d < 2; d++) begin
            if (kind == 2) begin
                check_eq($sformatf("%s/ws%0d/rdy_n", tag, d), rn[d], 0);
                check_eq($sformatf("%s/ws%0d/err_n", tag, d), en[d], 1);
                check_eq($sformatf("%s/ws%0d/err_cyc", tag, d), ec[d], 1);
            end else begin
                check_eq($sformatf("%s/ws%0d/rdy_n", tag, d), rn[d], 1);
                check_eq($sformatf("%s/ws%0d/rdy_cyc", tag, d), rc[d], d + 1);
                check_eq($sformatf("%s/ws%0d/err_n", tag, d), en[d], in_range ? 0 : 1);
                check_eq($sformatf("%s/ws%0d/err_rdy", tag, d), ear[d], !in_range);
                if (kind == 0)
                    check_eq($sformatf("%s/ws%0d/rdata", tag, d), dr[d], exp_dout);
            end
        end
        if (kind == 1 && in_range) begin mem_m[addr[7:0]] = din; exp_wr++; end
        if (kind == 0 && in_range) exp_rd++;
        check_regs(tag);
    endtask

    initial begin
        int n0, n1, e0, e1;
        logic [15:0] a;
        exp_dout = 16'h0; exp_rd = 16'h0; exp_wr = 16'h0;
        for (int i = 0; i < 256; i++) mem_m[i] = 16'h0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst/rdy0", if0.mem_ready, 1'b0);
        check_eq("rst/rdy1", if1.mem_ready, 1'b0);
        check_eq("rst/err1", if1.err, 1'b0);
        check_eq("rst/st1", st1, 2'd0);
        check_regs("rst");
        rst = 1'b0;

        // Write then read back through the same address.
        run_txn(1, 16'h0005, 16'hBEEF, "t1_wr");
        run_txn(0, 16'h0005, 16'h0000, "t1_rd");

        // Give every address the random phase touches a defined value.
        for (int i = 0; i < 16; i++) run_txn(1, 16'(i), 16'($urandom_range(0, 65535)), "pre");
        run_txn(1, 16'h00FF, 16'hA5A5, "pre_top");

        run_txn(2, 16'h0003, 16'h7777, "t3_both");
        run_txn(0, 16'h0003, 16'h0000, "t3_rd");
        run_txn(1, 16'h0100, 16'h1234, "t4_wr");
        run_txn(0, 16'h0100, 16'h0000, "t4_rd");
        run_txn(0, 16'h00FF, 16'h0000, "top_rd");

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 16'h0100 + 16'($urandom_range(0, 16'hFEFF));
                default: a = 16'($urandom_range(0, 15));
            endcase
            run_txn($urandom_range(0, 9) < 1 ? 2 : $urandom_range(0, 1), a,
                    16'($urandom_range(0, 65535)), $sformatf("rnd%0d", i));
        end

        // Reset while the write is still in flight; memory keeps the old word.
        run_txn(1, 16'h0007, 16'h0ACE, "t5_pre");
        @(negedge clk);
        drive(1'b0, 1'b1, 16'h0007, 16'h5555);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_dout = 16'h0; exp_rd = 16'h0; exp_wr = 16'h0;
        check_eq("t5/rdy1", if1.mem_ready, 1'b0);
        check_eq("t5/st1", st1, 2'd0);
        check_regs("t5_rst");
        run_txn(0, 16'h0007, 16'h0000, "t5_rd");

        // Counter wrap.
        @(negedge clk);
        force u_dut0.r_wr_count = 16'hFFFF;
        force u_dut1.r_wr_count = 16'hFFFF;
        @(posedge clk);
        #1;
        release u_dut0.r_wr_count;
        release u_dut1.r_wr_count;
        exp_wr = 16'hFFFF;
        run_txn(1, 16'h0009, 16'h4321, "t6_wrap");
        check_eq("t6/wr_zero", wr1, 16'h0000);

        // Continuous out-of-range reads: pulse spacing is WAIT_STATES+2.
        n0 = 0; n1 = 0; e0 = 0; e1 = 0;
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0100, 16'h0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 12) drive(1'b0, 1'b0, 16'h0, 16'h0);
            n0 += int'(if0.mem_ready); e0 += int'(if0.err);
            n1 += int'(if1.mem_ready); e1 += int'(if1.err);
        end
        repeat (4) @(negedge clk);
        exp_dout = 16'h0000;
        check_eq("cont/rdy0", n0, 6);
        check_eq("cont/rdy1", n1, 4);
        check_eq("cont/err0", e0, 6);
        check_eq("cont/err1", e1, 4);
        check_regs("cont");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
